// File: rtl/aes_pkg.sv
// Shared AES constants, round-constant table, forward S-box table and
// key-schedule FSM state type.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned AES_KW = 128;

  localparam logic [0:9][7:0] AES_RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Row r holds S-box entries 16r..16r+15, first byte at the MSB.
  localparam logic [0:255][7:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_EXPAND,
    KS_SERVE
  } ks_state_e;

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box; shared by SubWord here and encryption SubBytes.
import aes_pkg::*;

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte_c
);

  assign out_byte_c = AES_SBOX[in_byte];

endmodule

// File: rtl/aes_dec_key_sched.sv
// AES-128 key expansion into an 11-entry round-key store, served to the
// decryption datapath in reverse order (round NR down to 0) via valid/req.
import aes_pkg::*;

module aes_dec_key_sched #(
  parameter int unsigned NR = AES_NR,
  parameter int unsigned KW = AES_KW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_load,
  input  logic [KW-1:0] key_in,
  input  logic          rewind,
  input  logic          rk_req,
  output logic          busy,
  output logic          rk_valid,
  output logic [KW-1:0] rk_out,
  output logic [3:0]    rk_idx,
  output logic          rk_last
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  ks_state_e     state;
  logic [3:0]    round;
  logic [3:0]    rcon_idx;
  logic [3:0]    next_ptr;
  logic [KW-1:0] cur_rk;
  logic [KW-1:0] next_rk;
  logic [KW-1:0] rk_mem [0:NR];
  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   rot_w, sub_w, t_w;
  logic [31:0]   n0, n1, n2, n3;

  // One key-expansion round on the most recently produced round key.
  assign {w0, w1, w2, w3} = cur_rk;
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte    (rot_w[8*g +: 8]),
      .out_byte_c (sub_w[8*g +: 8])
    );
  end

  assign rcon_idx = (round != 4'd0 && round <= LAST_ROUND) ? round - 4'd1 : 4'd0;
  assign t_w      = sub_w ^ {AES_RCON[rcon_idx], 24'h0};
  assign n0       = w0 ^ t_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_rk  = {n0, n1, n2, n3};

  // Serve pointer: rewind wins over req; req at round 0 wraps for the next block.
  always_comb begin
    next_ptr = rk_idx;
    if (rewind) begin
      next_ptr = LAST_ROUND;
    end else if (rk_req) begin
      next_ptr = (rk_idx == 4'd0) ? LAST_ROUND : rk_idx - 4'd1;
    end
  end

  // Round-key store; contents are meaningless until a full expansion completes.
  always_ff @(posedge clk) begin
    if (key_load) begin
      rk_mem[0] <= key_in;
    end else if (state == KS_EXPAND) begin
      rk_mem[round] <= next_rk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= KS_IDLE;
      round    <= 4'd0;
      cur_rk   <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      rk_idx   <= 4'd0;
      rk_out   <= '0;
    end else if (key_load) begin
      state    <= KS_EXPAND;
      round    <= 4'd1;
      cur_rk   <= key_in;
      busy     <= 1'b1;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      rk_idx   <= 4'd0;
      rk_out   <= '0;
    end else begin
      case (state)
        KS_IDLE: begin
        end
        KS_EXPAND: begin
          cur_rk <= next_rk;
          if (round == LAST_ROUND) begin
            state    <= KS_SERVE;
            busy     <= 1'b0;
            rk_valid <= 1'b1;
            rk_idx   <= LAST_ROUND;
            rk_out   <= next_rk;
            rk_last  <= 1'b0;
          end else begin
            round <= round + 4'd1;
          end
        end
        KS_SERVE: begin
          rk_idx  <= next_ptr;
          rk_out  <= rk_mem[next_ptr];
          rk_last <= (next_ptr == 4'd0);
        end
        default: state <= KS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Scoreboard bench for aes_dec_key_sched using FIPS-197 key-expansion vectors.
module tb_aes_dec_key_sched;

  localparam logic [127:0] KEY_A      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst, key_load, rewind, rk_req;
  logic [127:0] key_in;
  logic         busy, rk_valid, rk_last;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  aes_dec_key_sched dut (
    .clk      (clk),
    .rst      (rst),
    .key_load (key_load),
    .key_in   (key_in),
    .rewind   (rewind),
    .rk_req   (rk_req),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last)
  );

  function automatic logic [127:0] fips_rk(input int i);
    case (i)
      0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
      1:  return 128'ha0fafe1788542cb123a339392a6c7605;
      2:  return 128'hf2c295f27a96b9435935807a7359f67f;
      3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
      4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
      5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
      7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      8:  return 128'head27321b58dbad2312bf5607f8d292f;
      9:  return 128'hac7766f319fadc2128d12941575c006e;
      default: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] idx, input logic [127:0] rk);
    e.idx  = idx;
    e.rk   = rk;
    e.last = (idx == 4'd0);
    exp_q.push_back(e);
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (rk_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_last !== 1'b0 || rk_idx !== 4'd0 || rk_out !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b last=%b idx=%0d rk=%h, expected all zero",
               busy, rk_valid, rk_last, rk_idx, rk_out);
    end
    for (int i = 0; i < 5; i++) begin
      rk_req = i[0];
      tick();
      checks++;
      if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_out !== '0 || rk_idx !== 4'd0) begin
        errors++;
        $display("FAIL idle_req: cycle %0d busy=%b valid=%b idx=%0d rk=%h, expected inactive",
                 i, busy, rk_valid, rk_idx, rk_out);
      end
    end
    rk_req = 1'b0;
  endtask

  task automatic test_expand();
    load_key(KEY_A);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (busy !== 1'b1 || rk_valid !== 1'b0) begin
        errors++;
        $display("FAIL expand_busy: cycle %0d busy=%b valid=%b, expected busy=1 valid=0",
                 i, busy, rk_valid);
      end
      tick();
    end
    push_exp(4'd10, fips_rk(10));
    e = exp_q.pop_front();
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b1 || rk_idx !== e.idx || rk_out !== e.rk || rk_last !== e.last) begin
      errors++;
      $display("FAIL expand_done: busy=%b valid=%b idx=%0d rk=%h, expected busy=0 valid=1 idx=%0d rk=%h",
               busy, rk_valid, rk_idx, rk_out, e.idx, e.rk);
    end
  endtask

  task automatic test_walk();
    for (int i = 10; i >= 0; i--) push_exp(4'(i), fips_rk(i));
    push_exp(4'd10, fips_rk(10));
    rk_req = 1'b1;
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== e.idx || rk_out !== e.rk || rk_last !== e.last) begin
        errors++;
        $display("FAIL walk: valid=%b idx=%0d rk=%h last=%b, expected idx=%0d rk=%h last=%b",
                 rk_valid, rk_idx, rk_out, rk_last, e.idx, e.rk, e.last);
      end
      tick();
    end
    rk_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== e.idx || rk_out !== e.rk || rk_last !== e.last) begin
      errors++;
      $display("FAIL wrap: valid=%b idx=%0d rk=%h last=%b, expected idx=%0d rk=%h last=%b",
               rk_valid, rk_idx, rk_out, rk_last, e.idx, e.rk, e.last);
    end
  endtask

  task automatic test_key2();
    int n;
    load_key(KEY_B);
    push_exp(4'd10, KEY_B_RK10);
    push_exp(4'd0, KEY_B);
    push_exp(4'd10, KEY_B_RK10);
    wait_valid(n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL key2_latency: valid after %0d cycles, expected 10", n);
    end
    e = exp_q.pop_front();
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== e.idx || rk_out !== e.rk) begin
      errors++;
      $display("FAIL key2_rk10: idx=%0d rk=%h, expected idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk);
    end
    rk_req = 1'b1;
    repeat (10) tick();
    rk_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (rk_idx !== e.idx || rk_out !== e.rk || rk_last !== e.last) begin
      errors++;
      $display("FAIL key2_rk0: idx=%0d rk=%h last=%b, expected idx=%0d rk=%h last=%b",
               rk_idx, rk_out, rk_last, e.idx, e.rk, e.last);
    end
    rk_req = 1'b1;
    tick();
    rk_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (rk_idx !== e.idx || rk_out !== e.rk || rk_last !== e.last) begin
      errors++;
      $display("FAIL key2_wrap: idx=%0d rk=%h last=%b, expected idx=%0d rk=%h last=%b",
               rk_idx, rk_out, rk_last, e.idx, e.rk, e.last);
    end
  endtask

  task automatic test_rewind();
    rk_req = 1'b1;
    repeat (6) tick();
    rk_req = 1'b0;
    checks++;
    if (rk_idx !== 4'd4) begin
      errors++;
      $display("FAIL rewind_setup: idx=%0d, expected 4", rk_idx);
    end
    rewind = 1'b1;
    rk_req = 1'b1;
    tick();
    rewind = 1'b0;
    rk_req = 1'b0;
    push_exp(4'd10, KEY_B_RK10);
    e = exp_q.pop_front();
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== e.idx || rk_out !== e.rk) begin
      errors++;
      $display("FAIL rewind: idx=%0d rk=%h, expected idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'd10 || rk_out !== KEY_B_RK10 || rk_last !== 1'b0) begin
        errors++;
        $display("FAIL stall: cycle %0d valid=%b idx=%0d rk=%h, expected idx=10 rk=%h",
                 i, rk_valid, rk_idx, rk_out, KEY_B_RK10);
      end
    end
  endtask

  task automatic test_abort();
    int n;
    load_key(KEY_A);
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_in_serve: valid=%b busy=%b, expected valid=0 busy=1", rk_valid, busy);
    end
    repeat (4) tick();
    load_key(KEY_B);
    push_exp(4'd10, KEY_B_RK10);
    wait_valid(n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL abort_latency: valid after %0d cycles, expected 10", n);
    end
    e = exp_q.pop_front();
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== e.idx || rk_out !== e.rk) begin
      errors++;
      $display("FAIL abort_rk10: idx=%0d rk=%h, expected idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk);
    end
  endtask

  task automatic test_reset_serve();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_idx !== 4'd0 || rk_out !== '0 || rk_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_serve: valid=%b busy=%b idx=%0d rk=%h, expected all zero",
               rk_valid, busy, rk_idx, rk_out);
    end
    rk_req = 1'b1;
    rewind = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_out !== '0) begin
        errors++;
        $display("FAIL post_reset_idle: cycle %0d valid=%b busy=%b rk=%h, expected inactive",
                 i, rk_valid, busy, rk_out);
      end
    end
    rk_req = 1'b0;
    rewind = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    key_load = 1'b0;
    key_in   = '0;
    rewind   = 1'b0;
    rk_req   = 1'b0;
    test_reset();
    test_expand();
    test_walk();
    test_key2();
    test_rewind();
    test_abort();
    test_reset_serve();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
